ads_spi_frame_receiver: RTL and testbench
=========================================

Name: ads_spi_frame_receiver

Overview:
- Receives one ADS131A0X output frame on DOUT, sampled with the SPI_SCLK and CS_n that our master drives.
- Runs on system_clock and oversamples the pin signals; it does not run on SCLK.
- Deserialises WORDS_PER_FRAME words of WORD_BITS bits (status word, channel words, trailing CRC word) and presents each as a single-cycle valid strobe.
- Sits between the pin pads and the sample FIFO/register bank; flags truncated frames.

Parameters:
- WORD_BITS, 24: bits per word, MSB first.
- WORDS_PER_FRAME, 6: words per frame (status + 4 channels + CRC).
- SAMPLE_FALLING, 1: 1 samples DOUT on SCLK falling edge (CPHA=1); 0 samples on rising edge.
- IDX_W, 3: width of word_index; must satisfy 2^IDX_W >= WORDS_PER_FRAME.

Ports:
- system_clock  in  1  sole clock; 50 MHz nominal.
- reset  in  1  synchronous, active-high.
- spi_cs_n  in  1  pin-level chip select, asynchronous to system_clock.
- spi_sclk  in  1  pin-level SCLK; must be <= system_clock/4.
- spi_miso  in  1  ADC DOUT, pin level.
- word_data  out  WORD_BITS  assembled word; holds its value until the next word_valid.
- word_valid  out  1  one-cycle strobe.
- word_index  out  IDX_W  0..WORDS_PER_FRAME-1; meaningful only with word_valid.
- frame_done  out  1  one-cycle strobe, coincident with the last word's word_valid.
- frame_error  out  1  one-cycle strobe; frame truncated.
- crc_error  out  1  one-cycle strobe with frame_done; 0 unless the CRC feature is compiled in.
- busy  out  1  high in ACTIVE and DONE.

Behaviour:
- Input capture: spi_cs_n, spi_sclk, spi_miso each pass through a 2-FF synchroniser.
- Edge detection: a third register on the synchronised SCLK and CS drives edge detection. The sampling edge is selected by SAMPLE_FALLING. MISO is taken from the same synchroniser stage as SCLK.
- Reset: every output is 0, state = IDLE, shift register and counters are 0. Synchroniser flops reset with CS=1, SCLK=0, MISO=0.
- States:
  - IDLE: waits for a falling edge on synchronised CS, then -> ACTIVE with bit_cnt=0 and word_cnt=0. CS already low when reset releases is not a start; the frame is ignored until CS goes high and falls again.
  - ACTIVE: on each sampling edge, shift left with MISO into the LSB and increment bit_cnt. When bit_cnt reaches WORD_BITS-1 on an edge, load the word out next cycle with word_valid=1 and word_index=word_cnt, clear bit_cnt, increment word_cnt. If that word is the last one, also pulse frame_done and go -> DONE.
  - DONE: all sampling edges are ignored (extra SCLK cycles do not corrupt data). A rising edge on CS -> IDLE.
  - CS rising edge in ACTIVE: pulse frame_error for 1 cycle, discard the partial word, go -> IDLE. No word_valid or frame_done is issued for the partial word.
- Simultaneous CS rising edge and sampling edge in the same cycle: CS wins; the bit is dropped and frame_error fires.
- Sampling edges while CS is high: ignored in IDLE.
- Latency: word_valid asserts exactly 4 system_clock cycles after the final sampling edge of a word reaches the pin (2 sync + 1 edge detect + 1 output register).
- Counter widths: bit_cnt = clog2(WORD_BITS), no wrap beyond WORD_BITS-1. word_cnt = IDX_W.
- reset asserted mid-frame: immediate return to IDLE with no strobes. The frame in progress is ignored per the IDLE rule above.

Optional Feature:
- Macro: ADS_SPI_RX_CRC_EN.
- Defined: a CRC-16-CCITT engine (polynomial 0x1021, init 0xFFFF, MSB first) runs over every bit of words 0..WORDS_PER_FRAME-2. The last word's upper 16 bits are compared with the CRC result; on mismatch, crc_error pulses with frame_done. The CRC is reinitialised on entry to ACTIVE.
- Undefined: no CRC logic is generated; crc_error is tied to 0; the last word is delivered unchecked.

Decomposition:
- Shared package ads_spi_pkg holds: state encoding (IDLE, ACTIVE, DONE), CRC polynomial/init constants, and default WORD_BITS/WORDS_PER_FRAME shared with spi_sclk_generator.
- One sub-module: ads_spi_crc16 (serial bit-wise CRC with init and enable inputs), instantiated only under ADS_SPI_RX_CRC_EN.

Test Plan:
- Nominal frame: CS low, 144 SCLK cycles at 4.167 MHz, words 0xC00000, 0x123456, 0xABCDEF, 0x000001, 0x7FFFFF, 0x800000 → six word_valid with index 0..5 and matching data; frame_done with index 5; no error.
- Truncation: CS rises after 30 bits → one word_valid (index 0), frame_error pulse, no frame_done. The next full frame is received correctly.
- Overrun: 10 extra SCLK cycles after the last word with CS still low → no further word_valid; next frame index starts at 0.
- Reset mid-frame after 50 bits, with CS held low → no strobes until CS toggles high then low. The following frame is correct.
- Edge/CS collision: CS rise and the 24th sampling edge in the same system_clock cycle → frame_error; no word_valid for that word.
- CRC (macro defined): correct CRC in word 5 → crc_error=0. Flip one bit of word 2 → crc_error=1 with frame_done.

Source files
------------

// File: rtl/ads_spi_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the ADS131A0x SPI frame path (receiver and SCLK generator).
package ads_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } ads_rx_state_e;

    localparam int unsigned ADS_WORD_BITS       = 24;
    localparam int unsigned ADS_WORDS_PER_FRAME = 6;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One MSB-first CRC-16-CCITT step for a single input bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
    endfunction

endpackage

// File: rtl/ads_spi_crc16.sv
`timescale 1ns/1ps
// Serial bit-wise CRC-16-CCITT: init_i reloads the seed, en_i folds in bit_i.
module ads_spi_crc16
    import ads_spi_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = CRC16_INIT;
        end else if (en_i) begin
            crc_d = crc16_step(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/ads_spi_frame_receiver.sv
`timescale 1ns/1ps
// Oversampling ADS131A0x DOUT frame deserialiser on system_clock.
// Define ADS_SPI_RX_CRC_EN to check the trailing CRC word.
module ads_spi_frame_receiver
    import ads_spi_pkg::*;
#(
    parameter int unsigned WORD_BITS       = ADS_WORD_BITS,
    parameter int unsigned WORDS_PER_FRAME = ADS_WORDS_PER_FRAME,
    parameter int unsigned SAMPLE_FALLING  = 1,
    parameter int unsigned IDX_W           = 3
) (
    input  logic                 system_clock,
    input  logic                 reset,
    input  logic                 spi_cs_n,
    input  logic                 spi_sclk,
    input  logic                 spi_miso,
    output logic [WORD_BITS-1:0] word_data,
    output logic                 word_valid,
    output logic [IDX_W-1:0]     word_index,
    output logic                 frame_done,
    output logic                 frame_error,
    output logic                 crc_error,
    output logic                 busy
);

    localparam int unsigned          BIT_CNT_W = $clog2(WORD_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(WORD_BITS - 1);
    localparam logic [IDX_W-1:0]     LAST_WORD = IDX_W'(WORDS_PER_FRAME - 1);

    // [0],[1] synchroniser stages, [2] edge-detect stage
    logic [2:0] cs_q, sclk_q;
    logic [1:0] miso_q;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            cs_q   <= '1;
            sclk_q <= '0;
            miso_q <= '0;
        end else begin
            cs_q   <= {cs_q[1:0], spi_cs_n};
            sclk_q <= {sclk_q[1:0], spi_sclk};
            miso_q <= {miso_q[0], spi_miso};
        end
    end

    logic cs_fall, cs_rise, samp_edge, miso_bit;
    assign cs_fall   = cs_q[2] & ~cs_q[1];
    assign cs_rise   = ~cs_q[2] & cs_q[1];
    assign samp_edge = (SAMPLE_FALLING != 0) ? (sclk_q[2] & ~sclk_q[1]) : (~sclk_q[2] & sclk_q[1]);
    assign miso_bit  = miso_q[1];

    ads_rx_state_e          state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]       word_cnt_q, word_cnt_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic                   pend_q, pend_d, pend_last_q, pend_last_d;
    logic [1:0]             prime_q, prime_d;
    logic                   armed_q, armed_d;
    logic [WORD_BITS-1:0]   word_data_q, word_data_d;
    logic [IDX_W-1:0]       word_index_q, word_index_d;
    logic                   word_valid_q, word_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic                   frame_error_q, frame_error_d;
    logic                   crc_error_q, crc_error_d;
    logic                   crc_init, crc_en, crc_mismatch;

`ifdef ADS_SPI_RX_CRC_EN
    logic [15:0] crc_value;

    ads_spi_crc16 u_crc (
        .clk_i  (system_clock),
        .rst_i  (reset),
        .init_i (crc_init),
        .en_i   (crc_en),
        .bit_i  (miso_bit),
        .crc_o  (crc_value)
    );

    assign crc_mismatch = (shift_q[WORD_BITS-1 -: 16] != crc_value);
`else
    logic unused_crc;
    assign unused_crc   = crc_init ^ crc_en;
    assign crc_mismatch = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        shift_d       = shift_q;
        pend_d        = 1'b0;
        pend_last_d   = 1'b0;
        word_data_d   = word_data_q;
        word_index_d  = word_index_q;
        word_valid_d  = 1'b0;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;
        crc_error_d   = 1'b0;
        crc_init      = 1'b0;
        crc_en        = 1'b0;
        // CS is only trusted once a genuine high has come through the synchroniser
        prime_d       = (prime_q == 2'd2) ? prime_q : prime_q + 2'd1;
        armed_d       = armed_q | ((prime_q == 2'd2) & cs_q[1]);

        // A completed word is held in shift_q for one cycle, then published.
        if (pend_q) begin
            word_data_d  = shift_q;
            word_valid_d = 1'b1;
            frame_done_d = pend_last_q;
            crc_error_d  = pend_last_q & crc_mismatch;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (armed_q && cs_fall) begin
                    state_d    = ST_ACTIVE;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    crc_init   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    frame_error_d = 1'b1;
                    state_d       = ST_IDLE;
                end else if (samp_edge) begin
                    shift_d = {shift_q[WORD_BITS-2:0], miso_bit};
                    crc_en  = (word_cnt_q != LAST_WORD);
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d    = '0;
                        word_cnt_d   = word_cnt_q + 1'b1;
                        word_index_d = word_cnt_q;
                        pend_d       = 1'b1;
                        if (word_cnt_q == LAST_WORD) begin
                            pend_last_d = 1'b1;
                            state_d     = ST_DONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            shift_q       <= '0;
            pend_q        <= 1'b0;
            pend_last_q   <= 1'b0;
            prime_q       <= '0;
            armed_q       <= 1'b0;
            word_data_q   <= '0;
            word_index_q  <= '0;
            word_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            crc_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            shift_q       <= shift_d;
            pend_q        <= pend_d;
            pend_last_q   <= pend_last_d;
            prime_q       <= prime_d;
            armed_q       <= armed_d;
            word_data_q   <= word_data_d;
            word_index_q  <= word_index_d;
            word_valid_q  <= word_valid_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            crc_error_q   <= crc_error_d;
        end
    end

    assign word_data   = word_data_q;
    assign word_index  = word_index_q;
    assign word_valid  = word_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign crc_error   = crc_error_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ads_spi_frame_receiver.sv
`timescale 1ns/1ps
// Directed bench for ads_spi_frame_receiver: table of frames plus corner-case sequences.
module tb_ads_spi_frame_receiver;

    localparam int unsigned WB   = 24;
    localparam int unsigned NW   = 6;
    localparam int unsigned HALF = 6;   // SCLK half period in system clocks (50/12 MHz)

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        sclk = 1'b0;
    logic        miso = 1'b0;
    logic [23:0] word_data;
    logic        word_valid;
    logic [2:0]  word_index;
    logic        frame_done, frame_error, crc_error, busy;

    always #10 clk = ~clk;

    ads_spi_frame_receiver #(
        .WORD_BITS       (WB),
        .WORDS_PER_FRAME (NW),
        .SAMPLE_FALLING  (1),
        .IDX_W           (3)
    ) dut (
        .system_clock (clk),
        .reset        (rst),
        .spi_cs_n     (cs_n),
        .spi_sclk     (sclk),
        .spi_miso     (miso),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_index   (word_index),
        .frame_done   (frame_done),
        .frame_error  (frame_error),
        .crc_error    (crc_error),
        .busy         (busy)
    );

    typedef logic [NW-1:0][WB-1:0] frame_t;

    typedef struct {
        int unsigned nbits;
        int unsigned extra;
        frame_t      w;
        int unsigned exp_valid;
        int unsigned exp_done;
        int unsigned exp_err;
    } vec_t;

    typedef struct {
        logic [23:0] data;
        logic [2:0]  idx;
        logic        done;
        logic        crc;
        int unsigned lat;
    } ev_t;

    ev_t         evq[$];
    int unsigned n_done = 0, n_err = 0, n_crc_stray = 0;
    time         last_fall_t = 0;
    int          checks = 0, failures = 0;
    logic        last_crc = 1'b0;

    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (word_valid) begin
                e.data = word_data;
                e.idx  = word_index;
                e.done = frame_done;
                e.crc  = crc_error;
                e.lat  = int'(($time - last_fall_t) / 20);
                evq.push_back(e);
            end
            if (frame_done)  n_done++;
            if (frame_error) n_err++;
            if (crc_error && !frame_done) n_crc_stray++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input frame_t w);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < int'(NW) - 1; i++) begin
            for (int b = int'(WB) - 1; b >= 0; b--) begin
                fb = c[15] ^ w[i][b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    function automatic logic crc_exp(input frame_t w);
`ifdef ADS_SPI_RX_CRC_EN
        return w[NW-1][WB-1 -: 16] != crc_model(w);
`else
        return 1'b0;
`endif
    endfunction

    function automatic vec_t mk(input int unsigned nbits, input int unsigned extra, input frame_t w,
                                input int unsigned ev, input int unsigned ed, input int unsigned ee);
        vec_t v;
        v.nbits = nbits; v.extra = extra; v.w = w;
        v.exp_valid = ev; v.exp_done = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic drive_bits(input frame_t w, input int unsigned start, input int unsigned n);
        for (int unsigned b = start; b < start + n; b++) begin
            if (b < NW * WB) miso = w[b / WB][WB - 1 - (b % WB)];
            else             miso = b[0];
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            last_fall_t = $time;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic send_frame(input vec_t v);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        drive_bits(v.w, 0, v.nbits + v.extra);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic clear_events();
        evq.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic check_frame(input vec_t v, input string tag);
        check({tag, "_nvalid"}, evq.size(), v.exp_valid);
        check({tag, "_ndone"}, n_done, v.exp_done);
        check({tag, "_nerr"}, n_err, v.exp_err);
        foreach (evq[i]) begin
            if (i < int'(NW)) begin
                check($sformatf("%s_data%0d", tag, i), evq[i].data, v.w[i]);
                check($sformatf("%s_idx%0d", tag, i), evq[i].idx, i);
                check($sformatf("%s_done%0d", tag, i), evq[i].done, (i == int'(NW) - 1));
                check($sformatf("%s_lat%0d", tag, i), evq[i].lat, 4);
                if (evq[i].done) begin
                    check($sformatf("%s_crc", tag), evq[i].crc, crc_exp(v.w));
                    last_crc = evq[i].crc;
                end
            end
        end
        check({tag, "_busy_end"}, busy, 0);
        clear_events();
    endtask

    initial begin
        vec_t   vecs[5];
        frame_t f;
        logic [15:0] c;

        vecs[0] = mk(144, 0, {24'h800000, 24'h7FFFFF, 24'h000001, 24'hABCDEF, 24'h123456, 24'hC00000}, 6, 1, 0);
        vecs[1] = mk(30,  0, {24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h5A5A5A, 24'hA5A5A5}, 1, 0, 1);
        vecs[2] = mk(144, 0, {24'h666666, 24'h555555, 24'h444444, 24'h333333, 24'h222222, 24'h111111}, 6, 1, 0);
        vecs[3] = mk(144, 10, {24'hEF0123, 24'hDEADBE, 24'h0F0F0F, 24'hF0F0F0, 24'h000000, 24'hFFFFFF}, 6, 1, 0);
        vecs[4] = mk(144, 0, {24'h0ABCDE, 24'h987654, 24'h000100, 24'h800001, 24'h7E7E7E, 24'h654321}, 6, 1, 0);

        repeat (3) @(negedge clk);
        check("rst_valid", word_valid, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_error, 0);
        check("rst_crc", crc_error, 0);
        check("rst_busy", busy, 0);
        check("rst_data", word_data, 0);
        check("rst_idx", word_index, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i]);
            check_frame(vecs[i], $sformatf("vec%0d", i));
            if (vecs[i].exp_done != 0) check($sformatf("hold%0d", i), word_data, vecs[i].w[NW-1]);
        end

        // Reset mid-frame with CS held low: the rest of the frame must be ignored.
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        drive_bits(vecs[2].w, 0, 50);
        check("prerst_nvalid", evq.size(), 2);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_events();
        drive_bits(vecs[2].w, 50, 94);
        repeat (HALF) @(negedge clk);
        check("midrst_nvalid", evq.size(), 0);
        check("midrst_ndone", n_done, 0);
        check("midrst_nerr", n_err, 0);
        check("midrst_busy", busy, 0);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        clear_events();
        send_frame(vecs[0]);
        check_frame(vecs[0], "post_rst");

        // CS rise on the same system clock as the 24th sampling edge.
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        drive_bits(vecs[4].w, 0, 10);
        check("coll_busy", busy, 1);
        drive_bits(vecs[4].w, 10, 13);
        miso = vecs[4].w[0][0];
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        check("coll_nvalid", evq.size(), 0);
        check("coll_nerr", n_err, 1);
        check("coll_ndone", n_done, 0);
        check("coll_busy_end", busy, 0);
        clear_events();
        send_frame(vecs[4]);
        check_frame(vecs[4], "post_coll");

`ifdef ADS_SPI_RX_CRC_EN
        f = vecs[2].w;
        c = crc_model(f);
        f[NW-1] = {c, 8'h5A};
        send_frame(mk(144, 0, f, 6, 1, 0));
        check_frame(mk(144, 0, f, 6, 1, 0), "crc_good");
        check("crc_ok", last_crc, 0);
        f[2][7] = ~f[2][7];
        send_frame(mk(144, 0, f, 6, 1, 0));
        check_frame(mk(144, 0, f, 6, 1, 0), "crc_flip");
        check("crc_bad", last_crc, 1);
`else
        f = '0;
        c = '0;
`endif

        check("crc_stray", n_crc_stray, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
